udp_packet_arbiter: RTL

Packet-level round-robin arbiter that shares one 40 Gbps UDP sum/max processing engine among several 256-bit ingress streams. It sits between the ingress ports and the engine input. It locks a grant for a whole fixed-length packet, then rotates to the next requesting port. A small in-order port-ID queue records which port owns each packet, so the result demux downstream can return each engine result to the right port.

---
 rtl/udp_pkg.sv | 9 +
 rtl/udp_id_fifo.sv | 41 ++++
 rtl/udp_packet_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: shared types and defaults for the UDP packet arbiter and its port-ID queue.
package udp_pkg;
    typedef enum logic {IDLE, LOCK} arb_state_t;
    localparam int DATA_W_DEF        = 256;
    localparam int BEATS_PER_PKT_DEF = 64;
    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/udp_id_fifo.sv
// udp_id_fifo: in-order port-ID queue; err pulses when a pop arrives while empty.
module udp_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign err     = pop && empty;
    assign dout    = mem[rd];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/udp_packet_arbiter.sv
// udp_packet_arbiter: packet-locked round-robin arbiter feeding one UDP engine, with owner-ID queue.
// Define UDP_ARB_STATS_EN to add per-port completed-packet counters on Pkt_count.
module udp_packet_arbiter
    import udp_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int BEATS_PER_PKT = BEATS_PER_PKT_DEF,
    parameter int ID_DEPTH      = 4,
    localparam int PW = port_id_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] In_data,
    input  logic [NUM_PORTS-1:0]        In_valid,
    output logic [NUM_PORTS-1:0]        In_ready,
    output logic [DATA_W-1:0]           Eng_data,
    output logic                        Eng_valid,
    input  logic                        Eng_ready,
    input  logic                        Res_valid,
    input  logic                        Res_ready,
    output logic [PW-1:0]               Res_port,
    output logic                        Res_port_valid,
    output logic                        Busy,
    output logic                        Id_err
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]     Pkt_count
`endif
);
    localparam int CW = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    arb_state_t    state, state_nxt;
    logic [PW-1:0] grant, last_grant, sel, idx, head;
    logic [CW-1:0] beat_cnt;
    logic          sel_ok, push, hs, last_beat, full, empty, fifo_err;
    // Descending scan so the port closest after last_grant is written last and wins.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = PW'((int'(last_grant) + i) % NUM_PORTS);
            if (In_valid[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end
    assign push      = state == IDLE && sel_ok && !full;
    assign hs        = Eng_valid && Eng_ready;
    assign last_beat = hs && beat_cnt == CW'(BEATS_PER_PKT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (push ? LOCK : IDLE) : (last_beat ? IDLE : LOCK);
    end
    always_comb begin
        Busy      = state == LOCK;
        Eng_data  = Busy ? In_data[grant*DATA_W +: DATA_W] : '0;
        Eng_valid = Busy && In_valid[grant];
        In_ready  = (Busy && Eng_ready) ? NUM_PORTS'(1) << grant : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= '0;
            last_grant <= PW'(NUM_PORTS - 1);
            beat_cnt   <= '0;
            Id_err     <= 1'b0;
        end else begin
            if (push) begin
                grant    <= sel;
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (last_beat) last_grant <= grant;
            if (fifo_err) Id_err <= 1'b1;
        end
    end
    udp_id_fifo #(.W(PW), .DEPTH(ID_DEPTH)) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (Res_valid && Res_ready),
        .din   (sel),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .err   (fifo_err)
    );
    assign Res_port_valid = !empty;
    assign Res_port       = empty ? '0 : head;
`ifdef UDP_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) Pkt_count <= '0;
        else if (last_beat) Pkt_count[grant*16 +: 16] <= Pkt_count[grant*16 +: 16] + 16'd1;
    end
`endif
endmodule
